// File: rtl/maroc_dc_axil_slave.sv
// AXI4-Lite register bank for the maroc_dc configuration path: NUM_REGS R/W words and write strobes.
// Optional read-only status word at index NUM_REGS when MAROC_DC_AXIL_STATUS_EN is defined.
module maroc_dc_axil_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 4
) (
    input  logic                           s00_axi_aclk,
    input  logic                           s00_axi_areset,
    input  logic [ADDR_WIDTH-1:0]          s00_axi_awaddr,
    input  logic [2:0]                     s00_axi_awprot,
    input  logic                           s00_axi_awvalid,
    output logic                           s00_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s00_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s00_axi_wstrb,
    input  logic                           s00_axi_wvalid,
    output logic                           s00_axi_wready,
    output logic [1:0]                     s00_axi_bresp,
    output logic                           s00_axi_bvalid,
    input  logic                           s00_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s00_axi_araddr,
    input  logic [2:0]                     s00_axi_arprot,
    input  logic                           s00_axi_arvalid,
    output logic                           s00_axi_arready,
    output logic [DATA_WIDTH-1:0]          s00_axi_rdata,
    output logic [1:0]                     s00_axi_rresp,
    output logic                           s00_axi_rvalid,
    input  logic                           s00_axi_rready,
`ifdef MAROC_DC_AXIL_STATUS_EN
    input  logic [DATA_WIDTH-1:0]          status_in,
`endif
    output logic [DATA_WIDTH*NUM_REGS-1:0] reg_out,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);
    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int STRB_W = DATA_WIDTH / 8;

    localparam logic [1:0] W_IDLE   = 2'd0;
    localparam logic [1:0] W_GOT_AW = 2'd1;
    localparam logic [1:0] W_GOT_W  = 2'd2;
    localparam logic [1:0] W_RESP   = 2'd3;
    localparam logic       R_IDLE   = 1'b0;
    localparam logic       R_RESP   = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                           ready_en_q;
    logic [1:0]                     w_state_q, w_state_d;
    logic                           r_state_q;
    logic [IDX_W-1:0]               aw_idx_q;
    logic [DATA_WIDTH-1:0]          wdata_q;
    logic [STRB_W-1:0]              wstrb_q;
    logic [DATA_WIDTH*NUM_REGS-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]            pulse_q, pulse_d;
    logic [1:0]                     bresp_q, rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]          rdata_q, rdata_d;

    logic                           aw_hs, w_hs, ar_hs, commit, wr_ok;
    logic [IDX_W-1:0]               wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0]          wr_data;
    logic [STRB_W-1:0]              wr_strb;
    logic                           unused_ok;

    // Readies stay low until the first edge after reset releases.
    assign s00_axi_awready = ready_en_q && (w_state_q == W_IDLE || w_state_q == W_GOT_W);
    assign s00_axi_wready  = ready_en_q && (w_state_q == W_IDLE || w_state_q == W_GOT_AW);
    assign s00_axi_arready = ready_en_q && (r_state_q == R_IDLE);
    assign s00_axi_bvalid  = (w_state_q == W_RESP);
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_rvalid  = (r_state_q == R_RESP);
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = rresp_q;
    assign reg_out         = regs_q;
    assign reg_wr_pulse    = pulse_q;

    assign aw_hs = s00_axi_awvalid && s00_axi_awready;
    assign w_hs  = s00_axi_wvalid && s00_axi_wready;
    assign ar_hs = s00_axi_arvalid && s00_axi_arready;

    // A channel completing on the commit edge supplies its live value, not the latched one.
    assign wr_idx  = aw_hs ? s00_axi_awaddr[ADDR_WIDTH-1:2] : aw_idx_q;
    assign wr_data = w_hs ? s00_axi_wdata : wdata_q;
    assign wr_strb = w_hs ? s00_axi_wstrb : wstrb_q;
    assign wr_ok   = int'(wr_idx) < NUM_REGS;
    assign rd_idx  = s00_axi_araddr[ADDR_WIDTH-1:2];

    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    always_comb begin
        w_state_d = w_state_q;
        commit    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) commit = 1'b1;
                else if (aw_hs)    w_state_d = W_GOT_AW;
                else if (w_hs)     w_state_d = W_GOT_W;
            end
            W_GOT_AW: if (w_hs) commit = 1'b1;
            W_GOT_W:  if (aw_hs) commit = 1'b1;
            default:  if (s00_axi_bready) w_state_d = W_IDLE;
        endcase
        if (commit) w_state_d = W_RESP;
    end

    always_comb begin
        regs_d  = regs_q;
        pulse_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (commit && int'(wr_idx) == i) begin
                pulse_d[i] = 1'b1;
                for (int b = 0; b < STRB_W; b++) begin
                    if (wr_strb[b]) regs_d[DATA_WIDTH*i+8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(rd_idx) == i) begin
                rdata_d = regs_q[DATA_WIDTH*i +: DATA_WIDTH];
                rresp_d = RESP_OKAY;
            end
        end
`ifdef MAROC_DC_AXIL_STATUS_EN
        if (int'(rd_idx) == NUM_REGS) begin
            rdata_d = status_in;
            rresp_d = RESP_OKAY;
        end
`endif
    end

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            ready_en_q <= 1'b0;
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            regs_q     <= '0;
            pulse_q    <= '0;
            bresp_q    <= RESP_OKAY;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            ready_en_q <= 1'b1;
            w_state_q  <= w_state_d;
            regs_q     <= regs_d;
            pulse_q    <= pulse_d;
            if (aw_hs) aw_idx_q <= s00_axi_awaddr[ADDR_WIDTH-1:2];
            if (w_hs) begin
                wdata_q <= s00_axi_wdata;
                wstrb_q <= s00_axi_wstrb;
            end
            if (commit) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (r_state_q == R_IDLE) begin
                if (ar_hs) begin
                    r_state_q <= R_RESP;
                    rdata_q   <= rdata_d;
                    rresp_q   <= rresp_d;
                end
            end else if (s00_axi_rready) begin
                r_state_q <= R_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_maroc_dc_axil_slave.sv
// Directed bench for maroc_dc_axil_slave; covers the status word when MAROC_DC_AXIL_STATUS_EN is defined.
module tb_maroc_dc_axil_slave;
    logic         clk, rst;
    logic [4:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [127:0] reg_out;
    logic [3:0]   reg_wr_pulse;
`ifdef MAROC_DC_AXIL_STATUS_EN
    logic [31:0]  status_in;
`endif

    int checks = 0;
    int failures = 0;
    int pulse_cnt [4];

    maroc_dc_axil_slave dut (
        .s00_axi_aclk(clk), .s00_axi_areset(rst),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot),
        .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot),
        .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
        .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
`ifdef MAROC_DC_AXIL_STATUS_EN
        .status_in(status_in),
`endif
        .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (reg_wr_pulse[i] === 1'b1) pulse_cnt[i]++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents AW from cycle aw_at and W from cycle w_at; lat_ok is bvalid one cycle after the later handshake.
    task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_at, input int w_at, output logic [1:0] resp,
                            output bit lat_ok);
        int n;
        bit aw_done, w_done, aw_fire, w_fire;
        aw_done = 0; w_done = 0; n = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = (aw_at == 0); wvalid = (w_at == 0);
        while (!(aw_done && w_done) && n < 20) begin
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            tick();
            n++;
            if (aw_fire) begin awvalid = 0; aw_done = 1; end
            if (w_fire)  begin wvalid = 0;  w_done = 1;  end
            if (!aw_done && n >= aw_at) awvalid = 1;
            if (!w_done && n >= w_at) wvalid = 1;
        end
        awvalid = 0; wvalid = 0;
        lat_ok = (bvalid === 1'b1);
        n = 0;
        while (bvalid !== 1'b1 && n < 20) begin tick(); n++; end
        resp = bresp;
        bready = 1; tick(); bready = 0;
    endtask

    task automatic do_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp,
                           output bit lat_ok);
        int n;
        bit fire;
        araddr = addr; arvalid = 1; n = 0; fire = 0;
        while (!fire && n < 20) begin fire = (arready === 1'b1); tick(); n++; end
        arvalid = 0;
        lat_ok = (rvalid === 1'b1);
        n = 0;
        while (rvalid !== 1'b1 && n < 20) begin tick(); n++; end
        data = rdata; resp = rresp;
        rready = 1; tick(); rready = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        awaddr = 0; araddr = 0; awprot = 0; arprot = 0; awvalid = 0; wvalid = 0; bready = 0;
        arvalid = 0; rready = 0; wdata = 0; wstrb = 0;
`ifdef MAROC_DC_AXIL_STATUS_EN
        status_in = 32'hCAFE0001;
`endif
        repeat (3) tick();
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, bresp, rresp} !== 9'b0) begin
            failures++;
            $display("FAIL reset_ctrl got %b want 0", {awready, wready, arready, bvalid, rvalid, bresp, rresp});
        end
        checks++;
        if ({rdata, reg_out, reg_wr_pulse} !== 164'b0) begin
            failures++; $display("FAIL reset_data got rdata=%h reg_out=%h pulse=%b want 0", rdata, reg_out, reg_wr_pulse);
        end
        @(negedge clk);
        rst = 0;
        #1;
        checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            failures++; $display("FAIL ready_before_edge got %b want 000", {awready, wready, arready});
        end
        tick();
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            failures++; $display("FAIL ready_after_edge got %b want 111", {awready, wready, arready});
        end
    endtask

    task automatic test_basic();
        logic [1:0] resp; logic [31:0] d; bit lat;
        for (int i = 0; i < 4; i++) begin
            do_write(5'(4 * i), 32'(i + 1), 4'hF, 0, 0, resp, lat);
            checks++;
            if (resp !== 2'b00 || !lat) begin
                failures++; $display("FAIL basic_wr%0d got resp=%b lat=%0d want 00 1", i, resp, lat);
            end
        end
        checks++;
        if (reg_out !== 128'h00000004_00000003_00000002_00000001) begin
            failures++; $display("FAIL basic_reg_out got %h want 00000004000000030000000200000001", reg_out);
        end
        checks++;
        if (pulse_cnt[0] !== 1 || pulse_cnt[1] !== 1 || pulse_cnt[2] !== 1 || pulse_cnt[3] !== 1) begin
            failures++;
            $display("FAIL basic_pulses got %0d %0d %0d %0d want 1 1 1 1",
                     pulse_cnt[0], pulse_cnt[1], pulse_cnt[2], pulse_cnt[3]);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(5'(4 * i), d, resp, lat);
            checks++;
            if (d !== 32'(i + 1) || resp !== 2'b00 || !lat) begin
                failures++;
                $display("FAIL basic_rd%0d got %h/%b lat=%0d want %h/00 1", i, d, resp, lat, i + 1);
            end
        end
    endtask

    task automatic test_order();
        logic [1:0] resp; bit lat;
        do_write(5'h04, 32'hA5A5A5A5, 4'hF, 3, 0, resp, lat);
        checks++;
        if (resp !== 2'b00 || !lat || reg_out[63:32] !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL w_first got resp=%b lat=%0d reg1=%h want 00 1 a5a5a5a5", resp, lat, reg_out[63:32]);
        end
        do_write(5'h04, 32'h5A5A5A5A, 4'hF, 0, 0, resp, lat);
        checks++;
        if (resp !== 2'b00 || !lat || reg_out[63:32] !== 32'h5A5A5A5A) begin
            failures++;
            $display("FAIL same_cycle got resp=%b lat=%0d reg1=%h want 00 1 5a5a5a5a", resp, lat, reg_out[63:32]);
        end
        do_write(5'h04, 32'h0F0F0F0F, 4'hF, 0, 2, resp, lat);
        checks++;
        if (resp !== 2'b00 || !lat || reg_out[63:32] !== 32'h0F0F0F0F) begin
            failures++;
            $display("FAIL aw_first got resp=%b lat=%0d reg1=%h want 00 1 0f0f0f0f", resp, lat, reg_out[63:32]);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp; logic [31:0] d; bit lat; int p;
        do_write(5'h08, 32'h11223344, 4'hF, 0, 0, resp, lat);
        do_write(5'h08, 32'hFFFFFFFF, 4'b0101, 0, 0, resp, lat);
        checks++;
        if (resp !== 2'b00 || reg_out[95:64] !== 32'h11FF33FF) begin
            failures++; $display("FAIL strobe_reg got %h/%b want 11ff33ff/00", reg_out[95:64], resp);
        end
        do_read(5'h08, d, resp, lat);
        checks++;
        if (d !== 32'h11FF33FF || resp !== 2'b00) begin
            failures++; $display("FAIL strobe_rd got %h/%b want 11ff33ff/00", d, resp);
        end
        p = pulse_cnt[2];
        do_write(5'h08, 32'h00000000, 4'b0000, 0, 0, resp, lat);
        checks++;
        if (resp !== 2'b00 || reg_out[95:64] !== 32'h11FF33FF || pulse_cnt[2] !== p + 1) begin
            failures++;
            $display("FAIL strobe_zero got %h/%b pulses=%0d want 11ff33ff/00 %0d", reg_out[95:64], resp,
                     pulse_cnt[2], p + 1);
        end
        do_read(5'h0B, d, resp, lat);
        checks++;
        if (d !== 32'h11FF33FF || resp !== 2'b00) begin
            failures++; $display("FAIL low_bits_ignored got %h/%b want 11ff33ff/00", d, resp);
        end
    endtask

    task automatic test_unmapped();
        logic [1:0] resp; logic [31:0] d; bit lat; logic [127:0] snap; int p;
        snap = reg_out;
        p = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3];
        do_write(5'h10, 32'h87654321, 4'hF, 0, 0, resp, lat);
        checks++;
        if (resp !== 2'b10 || reg_out !== snap || pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] !== p) begin
            failures++; $display("FAIL unmapped_wr got resp=%b reg_out=%h want 10 %h, no pulse", resp, reg_out, snap);
        end
        do_read(5'h1C, d, resp, lat);
        checks++;
        if (d !== 32'h0 || resp !== 2'b10) begin
            failures++; $display("FAIL unmapped_rd got %h/%b want 00000000/10", d, resp);
        end
        do_read(5'h10, d, resp, lat);
        checks++;
`ifdef MAROC_DC_AXIL_STATUS_EN
        if (d !== 32'hCAFE0001 || resp !== 2'b00) begin
            failures++; $display("FAIL status_rd got %h/%b want cafe0001/00", d, resp);
        end
`else
        if (d !== 32'h0 || resp !== 2'b10) begin
            failures++; $display("FAIL idx4_rd got %h/%b want 00000000/10", d, resp);
        end
`endif
    endtask

    task automatic test_stall();
        logic [127:0] snap;
        awaddr = 5'h0C; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick();
        awaddr = 5'h00; wdata = 32'h12345678;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
                failures++;
                $display("FAIL b_stall%0d got bvalid=%b bresp=%b awready=%b wready=%b want 1 00 0 0",
                         i, bvalid, bresp, awready, wready);
            end
            tick();
        end
        awvalid = 0; wvalid = 0; bready = 1; tick(); bready = 0;
        checks++;
        if (bvalid !== 1'b0 || reg_out[127:96] !== 32'hDEADBEEF || reg_out[31:0] !== 32'h1) begin
            failures++;
            $display("FAIL b_release got bvalid=%b reg3=%h reg0=%h want 0 deadbeef 00000001",
                     bvalid, reg_out[127:96], reg_out[31:0]);
        end
        araddr = 5'h0C; arvalid = 1;
        tick();
        araddr = 5'h00;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || rresp !== 2'b00 || arready !== 1'b0) begin
                failures++;
                $display("FAIL r_stall%0d got rvalid=%b rdata=%h rresp=%b arready=%b want 1 deadbeef 00 0",
                         i, rvalid, rdata, rresp, arready);
            end
            tick();
        end
        arvalid = 0; rready = 1; tick(); rready = 0;
        checks++;
        if (rvalid !== 1'b0) begin
            failures++; $display("FAIL r_release got rvalid=%b want 0", rvalid);
        end
        snap = reg_out;
        checks++;
        if (snap[31:0] !== 32'h1) begin
            failures++; $display("FAIL stall_no_extra_write got reg0=%h want 00000001", snap[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        araddr = 5'h0C; arvalid = 1;
        awaddr = 5'h0C; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick();
        arvalid = 0; awvalid = 0; wvalid = 0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || bvalid !== 1'b1 || reg_out[127:96] !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL rd_wr_same_edge got rvalid=%b rdata=%h bvalid=%b reg3=%h want 1 deadbeef 1 cafef00d",
                     rvalid, rdata, bvalid, reg_out[127:96]);
        end
        checks++;
        if (reg_wr_pulse !== 4'b1000) begin
            failures++; $display("FAIL rd_wr_pulse got %b want 1000", reg_wr_pulse);
        end
        rready = 1; bready = 1; tick(); rready = 0; bready = 0;
        checks++;
        if (reg_wr_pulse !== 4'b0000 || bvalid !== 1'b0 || rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rd_wr_done got pulse=%b bvalid=%b rvalid=%b want 0000 0 0", reg_wr_pulse, bvalid, rvalid);
        end
    endtask

    task automatic test_reset_mid();
        awaddr = 5'h08; awvalid = 1;
        tick();
        awvalid = 0;
        rst = 1;
        #1;
        checks++;
        if (bvalid !== 1'b0 || reg_out !== 128'b0 || awready !== 1'b0) begin
            failures++; $display("FAIL mid_reset got bvalid=%b reg_out=%h awready=%b want 0 0 0", bvalid, reg_out, awready);
        end
        tick();
        @(negedge clk);
        rst = 0;
        tick();
        wdata = 32'h00000077; wstrb = 4'hF; wvalid = 1;
        tick();
        wvalid = 0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bvalid !== 1'b0 || reg_out !== 128'b0) begin
                failures++; $display("FAIL abort_%0d got bvalid=%b reg_out=%h want 0 0", i, bvalid, reg_out);
            end
            tick();
        end
        awaddr = 5'h00; awvalid = 1;
        tick();
        awvalid = 0;
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00 || reg_out !== 128'h77) begin
            failures++;
            $display("FAIL post_reset_wr got bvalid=%b bresp=%b reg_out=%h want 1 00 77", bvalid, bresp, reg_out);
        end
        bready = 1; tick(); bready = 0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
        test_reset();
        test_basic();
        test_order();
        test_strobe();
        test_unmapped();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/maroc_dc_axil_slave.md
Name: maroc_dc_axil_slave

Overview:
AXI4-Lite responder (slave) register bank for the maroc_dc configuration path; it is the far end of the master-driven write/read sequences the block bench issues. It holds NUM_REGS 32-bit read/write control registers, drives them onto a flat output bus and pulses a per-register write strobe. Unmapped addresses return SLVERR. It sits between the PS interconnect and MAROC data-collection logic.

Parameters:
DATA_WIDTH, 32, AXI data width; only 32 is supported.
ADDR_WIDTH, 5, byte-address width; word index = addr[ADDR_WIDTH-1:2].
NUM_REGS, 4, number of implemented R/W registers at word indices 0..NUM_REGS-1; NUM_REGS <= 2^(ADDR_WIDTH-2).

Ports:
s00_axi_aclk  in  1  the single clock
s00_axi_areset  in  1  asynchronous, active-high reset
s00_axi_awaddr  in  ADDR_WIDTH  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid / s00_axi_awready  in/out  1  AW handshake
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  byte strobes
s00_axi_wvalid / s00_axi_wready  in/out  1  W handshake
s00_axi_bresp  out  2  00 OKAY, 10 SLVERR
s00_axi_bvalid / s00_axi_bready  out/in  1  B handshake
s00_axi_araddr  in  ADDR_WIDTH  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid / s00_axi_arready  in/out  1  AR handshake
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  read response
s00_axi_rvalid / s00_axi_rready  out/in  1  R handshake
reg_out  out  32*NUM_REGS  register contents; reg i at bits [32i+31:32i]
reg_wr_pulse  out  NUM_REGS  one-cycle strobe for each committed OKAY write

Behaviour:
- Reset is asynchronous and active-high on s00_axi_areset; the block has one clock, s00_axi_aclk. While reset is asserted, all of the following are 0: every ready, bvalid, rvalid, bresp, rresp, rdata, reg_out and reg_wr_pulse. The ready outputs rise on the first clock edge after reset deasserts.
- Write FSM states: W_IDLE, W_GOT_AW, W_GOT_W, W_RESP.
  - awready is high in W_IDLE and W_GOT_W. wready is high in W_IDLE and W_GOT_AW.
  - AW and W may arrive in either order, or in the same cycle. Address and data are latched on their own handshakes.
  - When both are held, the write commits on the next edge and the FSM enters W_RESP with bvalid=1. For the OKAY case, the byte lanes selected by wstrb update, reg_out reflects the new value and reg_wr_pulse[i] is high for exactly that one cycle. Latency is 1 cycle after the later handshake.
  - The FSM stays in W_RESP, holding bvalid and bresp stable, until bready; it then returns to W_IDLE. awready and wready are low throughout W_RESP.
  - Word index >= NUM_REGS: no register changes, no pulse, bresp=10.
  - wstrb=0 to a valid index: bresp=00, no bytes change, pulse still fires.
- Read FSM states: R_IDLE, R_RESP.
  - arready is high only in R_IDLE.
  - On an AR handshake, rdata and rresp are registered and rvalid=1 on the next edge; latency is 1 cycle.
  - rdata and rresp are held until rready, then the FSM returns to R_IDLE.
  - Unmapped index: rdata=0, rresp=10.
- One outstanding write and one outstanding read at a time. The read and write channels are fully independent.
- If a read capture and a write commit to the same register happen on the same edge, the read returns the pre-write value.
- Address bits [1:0] are ignored. Word index bits above the implemented range are decoded fully and are not aliased.
- If reset asserts mid-transaction, the FSMs abort to idle, registers clear and no B or R response is issued.

Optional Feature:
MAROC_DC_AXIL_STATUS_EN.
- Defined: adds input status_in (32 bits).
  - Word index NUM_REGS is a read-only status register. Reads return status_in, sampled at the AR handshake, with OKAY.
  - Writes to that index return SLVERR and have no effect.
- Undefined: no status_in port, and index NUM_REGS is unmapped like any other.

Test Plan:
1. Reset, then AXI4-Lite writes 0x1,0x2,0x3,0x4 to addresses 0x0,0x4,0x8,0xC, then reads back the same addresses -> all bresp/rresp=00, rdata=1,2,3,4, reg_out=0x00000004_00000003_00000002_00000001, and exactly one reg_wr_pulse per write.
2. Present W (data 0xA5A5A5A5) 3 cycles before AW (addr 0x4) -> bvalid rises 1 cycle after the AW handshake, reg 1 = 0xA5A5A5A5. Repeat with AW and W in the same cycle -> same result.
3. Reg 2 holds 0x11223344; write 0xFFFFFFFF with wstrb=0101 -> reg 2 = 0x11FF33FF; read returns 0x11FF33FF.
4. Write to 0x10 and read 0x1C -> bresp=10, rresp=10, rdata=0, no reg_out change, no pulse. With MAROC_DC_AXIL_STATUS_EN defined and status_in=0xCAFE0001, read 0x10 -> 0xCAFE0001 OKAY, while write 0x10 -> SLVERR.
5. Hold bready low 10 cycles and rready low 10 cycles -> bvalid/bresp and rvalid/rdata stay stable, awready/wready/arready stay low, and no new handshake is accepted.
6. Assert reset after the AW handshake but before W -> no B response, reg_out=0, and after release a fresh write completes normally.
